// File: rtl/mux_8to1.sv
// mux_8to1: registered 8-to-1 multiplexer; {S2,S1,S0} picks B0..B7 into O on enabled edges.
module mux_8to1 #(
  parameter int unsigned WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] O,
  input  logic             S0,
  input  logic             S1,
  input  logic             S2,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] B1,
  input  logic [WIDTH-1:0] B2,
  input  logic [WIDTH-1:0] B3,
  input  logic [WIDTH-1:0] B4,
  input  logic [WIDTH-1:0] B5,
  input  logic [WIDTH-1:0] B6,
  input  logic [WIDTH-1:0] B7
);
  logic [WIDTH-1:0] nxt;
  always_comb begin
    nxt = S2 ? (S1 ? (S0 ? B7 : B6) : (S0 ? B5 : B4))
             : (S1 ? (S0 ? B3 : B2) : (S0 ? B1 : B0));
  end
  always_ff @(posedge clk) begin
    if (rst) O <= RST_VAL;
    else if (en) O <= nxt;
  end
endmodule

// File: tb/tb_mux_8to1.sv
// tb_mux_8to1: table-driven and randomized checks of mux_8to1 at WIDTH=1 and WIDTH=8.
module tb_mux_8to1;
  typedef struct {
    logic       r;
    logic       e;
    logic [2:0] s;
    logic [7:0] bv;
    logic       x;
  } vec_t;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, en, s0, s1, s2;
  logic [7:0] bv1;
  logic [7:0] b8 [8];
  logic o1;
  logic [7:0] o8;
  logic m1;
  logic [7:0] m8;
  int cnt = 0;
  int bad = 0;
  vec_t tbl[$];
  mux_8to1 #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .O(o1), .S0(s0), .S1(s1), .S2(s2),
    .B0(bv1[0]), .B1(bv1[1]), .B2(bv1[2]), .B3(bv1[3]),
    .B4(bv1[4]), .B5(bv1[5]), .B6(bv1[6]), .B7(bv1[7])
  );
  mux_8to1 #(.WIDTH(8), .RST_VAL(8'h00)) u8 (
    .clk(clk), .rst(rst), .en(en), .O(o8), .S0(s0), .S1(s1), .S2(s2),
    .B0(b8[0]), .B1(b8[1]), .B2(b8[2]), .B3(b8[3]),
    .B4(b8[4]), .B5(b8[5]), .B6(b8[6]), .B7(b8[7])
  );
  function automatic vec_t mk(input logic r, input logic e, input logic [2:0] s,
                              input logic [7:0] bv, input logic x);
    vec_t v;
    v.r = r; v.e = e; v.s = s; v.bv = bv; v.x = x;
    return v;
  endfunction
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] x);
    cnt++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", n, a, x, $time);
    end
  endtask
  // Drive on the falling edge, advance the reference register, sample just after the rising edge.
  task automatic step(input logic r, input logic e, input logic [2:0] s);
    @(negedge clk);
    rst = r; en = e; {s2, s1, s0} = s;
    m1 = r ? 1'b0 : e ? bv1[s] : m1;
    m8 = r ? 8'h00 : e ? b8[s] : m8;
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [2:0] sw [8];
    sw = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    rst = 1'b0; en = 1'b0; {s2, s1, s0} = 3'd0; bv1 = 8'h00; m1 = 1'b0; m8 = 8'h00;
    for (int i = 0; i < 8; i++) b8[i] = 8'h10 + 8'(i);
    tbl.push_back(mk(1'b1, 1'b0, 3'd5, 8'hAA, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 3'd7, 8'hFF, 1'b0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1'b0, 1'b1, sw[i], 8'hAA, sw[i][0]));
    tbl.push_back(mk(1'b0, 1'b1, 3'd0, 8'h99, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 3'd4, 8'h99, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 3'd2, 8'h99, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd6, 8'h99, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd1, 8'h99, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd5, 8'h99, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd3, 8'h99, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 3'd7, 8'h99, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 3'd7, 8'h80, 1'b1));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(1'b0, 1'b0, 3'd0, 8'h80, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 3'd0, 8'h80, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd1, 8'hAA, 1'b1));
    tbl.push_back(mk(1'b1, 1'b1, 3'd3, 8'hAA, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd5, 8'hAA, 1'b1));
    tbl.push_back(mk(1'b0, 1'b1, 3'd6, 8'hAA, 1'b0));
    foreach (tbl[i]) begin
      bv1 = tbl[i].bv;
      step(tbl[i].r, tbl[i].e, tbl[i].s);
      chk($sformatf("tbl1[%0d]", i), {7'd0, o1}, {7'd0, tbl[i].x});
      chk($sformatf("tbl8[%0d]", i), o8, m8);
    end
    for (int s = 0; s < 8; s++) begin
      step(1'b0, 1'b1, 3'(s));
      chk($sformatf("w8_sel%0d", s), o8, 8'h10 + 8'(s));
    end
    for (int k = 0; k < 300; k++) begin
      bv1 = 8'($urandom);
      for (int i = 0; i < 8; i++) b8[i] = 8'($urandom);
      step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)));
      chk("rnd1", {7'd0, o1}, {7'd0, m1});
      chk("rnd8", o8, m8);
      bv1 = ~bv1;
      for (int i = 0; i < 8; i++) b8[i] = ~b8[i];
      {s2, s1, s0} = ~{s2, s1, s0};
      #2;
      chk("stable8", o8, m8);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cnt, bad);
    $finish;
  end
endmodule
